// File: rtl/unified_mem_responder_pkg.sv
// Shared definitions for the unified instruction/data memory responder:
// funct3 size codes, FSM state encoding and byte-lane masks.
package mem_resp_pkg;

    // RV32 load/store funct3 size codes (fetch uses F3_W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-enable masks for the lowest lane of each access size
    localparam logic [3:0] LANE_MASK_B = 4'b0001;
    localparam logic [3:0] LANE_MASK_H = 4'b0011;
    localparam logic [3:0] LANE_MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True for the five funct3 codes the responder knows how to size
    function automatic logic func3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/unified_mem_responder_lane_align.sv
// Combinational lane steering for the memory responder.
// Stores: byte enables plus the write data replicated into every lane.
// Loads: extracts the addressed byte/half and sign- or zero-extends it.
// Optional macro MEM_RESP_MISALIGN_ERR_EN: flag misaligned half/word
// accesses instead of silently forcing alignment.
module mem_lane_align
    import mem_resp_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] load_data,
    output logic        illegal,
    output logic        misalign
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte and half out of the fetched word
    always_comb begin
        sel_byte = rword[7:0];
        case (lane)
            2'd1:    sel_byte = rword[15:8];
            2'd2:    sel_byte = rword[23:16];
            2'd3:    sel_byte = rword[31:24];
            default: sel_byte = rword[7:0];
        endcase
        sel_half = lane[1] ? rword[31:16] : rword[15:0];
    end

    // Size decode: store enables/replicated data and load extension
    always_comb begin
        byte_en   = '0;
        wword     = '0;
        load_data = '0;
        illegal   = !func3_legal(func3);
        misalign  = 1'b0;
        case (func3)
            F3_B, F3_BU: begin
                byte_en   = LANE_MASK_B << lane;
                wword     = {4{wdata[7:0]}};
                load_data = func3[2] ? {24'd0, sel_byte}
                                     : {{24{sel_byte[7]}}, sel_byte};
            end
            F3_H, F3_HU: begin
                byte_en   = lane[1] ? (LANE_MASK_H << 2) : LANE_MASK_H;
                wword     = {2{wdata[15:0]}};
                load_data = func3[2] ? {16'd0, sel_half}
                                     : {{16{sel_half[15]}}, sel_half};
`ifdef MEM_RESP_MISALIGN_ERR_EN
                misalign  = lane[0];
`endif
            end
            F3_W: begin
                byte_en   = LANE_MASK_W;
                wword     = wdata;
                load_data = rword;
`ifdef MEM_RESP_MISALIGN_ERR_EN
                misalign  = (lane != 2'b00);
`endif
            end
            default: begin
                byte_en   = '0;
            end
        endcase
    end

endmodule

// File: rtl/unified_mem_responder.sv
// Responder for the core's shared instruction/data memory port.
// One request at a time over valid/ready, WAIT_STATES extra cycles of
// latency, then a byte-enabled access on a word array and a single-cycle
// registered response.
// Optional macro MEM_RESP_MISALIGN_ERR_EN: misaligned half/word accesses
// are refused with resp_err=1; otherwise alignment is forced.
module unified_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 1
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_BITS;

    state_t state;
    state_t next_state;

    logic [3:0]           counter;
    logic [ADDR_BITS-1:0] lat_index;
    logic [1:0]           lat_lane;
    logic [2:0]           lat_func3;
    logic [31:0]          lat_wdata;
    logic                 lat_write;

    logic [31:0] mem [DEPTH];
    logic [31:0] rword;

    logic [3:0]  byte_en;
    logic [31:0] wword;
    logic [31:0] load_data;
    logic        illegal;
    logic        misalign;

    logic accept;
    logic access;
    logic do_write;

    // Address bits above the array wrap around and are deliberately dropped
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_BITS+2];

    assign accept   = req_valid && req_ready;
    assign access   = (state == ST_WAIT) && (counter == 4'd0);
    assign do_write = access && lat_write && !illegal && !misalign;
    assign rword    = mem[lat_index];

    mem_lane_align u_align (
        .func3     (lat_func3),
        .lane      (lat_lane),
        .wdata     (lat_wdata),
        .rword     (rword),
        .byte_en   (byte_en),
        .wword     (wword),
        .load_data (load_data),
        .illegal   (illegal),
        .misalign  (misalign)
    );

    // Next-state and handshake outputs; ready everywhere except WAIT
    always_comb begin
        next_state = state;
        req_ready  = 1'b1;
        busy       = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) next_state = ST_WAIT;
            end
            ST_WAIT: begin
                req_ready = 1'b0;
                busy      = 1'b1;
                if (counter == 4'd0) next_state = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                next_state = req_valid ? ST_WAIT : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register and wait-state down-counter; reset aborts any request
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            counter <= 4'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                counter <= 4'(WAIT_STATES);
            end else if ((state == ST_WAIT) && (counter != 4'd0)) begin
                counter <= counter - 4'd1;
            end
        end
    end

    // Capture the request fields at acceptance
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lat_index <= '0;
            lat_lane  <= '0;
            lat_func3 <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
        end else if (accept) begin
            lat_index <= req_addr[ADDR_BITS+1:2];
            lat_lane  <= req_addr[1:0];
            lat_func3 <= req_func3;
            lat_wdata <= req_wdata;
            lat_write <= req_write;
        end
    end

    // Response data is only updated by an access and held otherwise
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (access) begin
            resp_rdata <= (lat_write || illegal || misalign) ? 32'd0 : load_data;
            resp_err   <= misalign;
        end
    end

    // Byte-enabled write into the word array (contents are never reset)
    always_ff @(posedge CLK) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[lat_index][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/unified_mem_responder.md
Name: unified_mem_responder

Overview:
- Responder side of the core's shared instruction/data memory port.
- Accepts one request at a time from the pipelined datapath: instruction fetch, or load/store sized by funct3. Handshake is valid/ready.
- Models a configurable number of wait states, then performs the access on a word-organised array.
- Returns one registered response per request, with load data steered and sign/zero-extended.
- Replaces the fixed slow-clock interleave with an explicit request/response contract.

Parameters:
- ADDR_BITS, 8, word-address width; array depth is 2^ADDR_BITS 32-bit words.
- WAIT_STATES, 1, extra cycles between acceptance and access; legal range 0..15.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept this cycle
- req_write  input  1  1 = store, 0 = load/fetch
- req_func3  input  3  RV32 funct3 size code; fetch uses 010
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle response strobe
- resp_rdata  output  32  load result; 0 for stores
- resp_err  output  1  error flag, qualified by resp_valid
- busy  output  1  high in WAIT

Behaviour:
- Clock and reset: single clock CLK; RST is asynchronous, active-high.
- Reset values:
  - state=IDLE, counter=0.
  - resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1.
  - Array contents are not reset.
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0, busy=1.
  - RESP: req_ready=1, resp_valid=1.
- Acceptance: occurs on a rising edge where req_valid && req_ready.
  - addr, func3, wdata and write are latched.
  - counter is loaded with WAIT_STATES.
  - Next state is WAIT.
- WAIT:
  - If counter!=0, decrement it and stay in WAIT.
  - If counter==0, perform the access on this edge and go to RESP.
- RESP: lasts exactly one cycle.
  - Goes to WAIT on a new acceptance, otherwise to IDLE.
  - Responses have no backpressure.
- Latency: a request accepted in cycle 0 gives resp_valid high in cycle WAIT_STATES+2.
  - Back-to-back throughput is one request per WAIT_STATES+2 cycles.
- Addressing:
  - Word index = addr[ADDR_BITS+1:2]; upper bits are ignored (wraps modulo depth).
  - Lane = addr[1:0].
- Loads:
  - 000 LB: sign-extended byte.
  - 100 LBU: zero-extended byte.
  - 001 LH: sign-extended half, selected by addr[1].
  - 101 LHU: zero-extended half.
  - 010 LW: full word.
- Stores: byte-enable writes.
  - SB writes lane addr[1:0].
  - SH writes the half selected by addr[1].
  - SW writes all 4 bytes.
  - Store responses give resp_rdata=0.
- Illegal func3 (011, 110, 111): no write, resp_rdata=0, response still issued.
- resp_rdata holds its value outside RESP until the next response.
- RST mid-operation: the FSM aborts immediately.
  - A store still in WAIT never writes.
  - No response is issued.

Optional Feature:
- Macro: MEM_RESP_MISALIGN_ERR_EN.
- Defined:
  - Misaligned accesses are not performed: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - The response carries resp_err=1 and resp_rdata=0.
  - The array is unchanged.
- Undefined:
  - Alignment is forced: halfword ignores addr[0]; word ignores addr[1:0].
  - resp_err is constant 0.

Decomposition:
- Shared package mem_resp_pkg:
  - funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding (ST_IDLE, ST_WAIT, ST_RESP).
  - Lane-mask constants.
  - Reuses the existing opcode/field defines.
- One natural sub-module, mem_lane_align (combinational): produces store byte-enables and the shifted write word, and does load lane extraction with sign/zero extension.
- FSM, counter and array live in unified_mem_responder.

Test Plan:
- Reset mid-operation: WAIT_STATES=3; SW 0xDEADBEEF to 0x10, then assert RST in the second WAIT cycle. Required: no resp_valid; a later LW 0x10 returns the prior contents (0x00000000 after preload).
- Store/load sizing: WAIT_STATES=1; SW 0x80FF7F01 to 0x20, then LB 0x21, LBU 0x23, LH 0x22, LHU 0x22, LW 0x20. Required results: 0x0000007F, 0x00000080, 0xFFFF80FF, 0x000080FF, 0x80FF7F01; each resp_valid in cycle 3 after acceptance.
- Byte stores: SB 0xAA to 0x31, then SH 0x1234 to 0x32 over a word of 0. Required: LW 0x30 returns 0x1234AA00.
- Back-to-back: WAIT_STATES=0; hold req_valid high with 4 loads. Required: acceptances every 2 cycles; resp_valid pulses in cycles 2, 4, 6, 8; req_ready never low in IDLE/RESP.
- Wrap and illegal: ADDR_BITS=8; SW 0x55 to 0x400, then LW 0x000. Required: returns 0x00000055. Then a func3=011 load. Required: resp_rdata=0, resp_valid high.
- Misalign: LH at 0x41 with MEM_RESP_MISALIGN_ERR_EN defined. Required: resp_err=1, resp_rdata=0. Without the macro: the halfword at 0x40 is returned, resp_err=0.
